hs_fifo_master: RTL and testbench

HS_FIFO_MASTER -- requirements
Module: hs_fifo_master

---
 rtl/hs_pkg.sv | 21 ++
 rtl/hs_fifo_ram.sv | 33 +++
 rtl/hs_fifo_master.sv | 71 +++++++
 tb/tb_hs_fifo_master.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared constants and helpers for the handshake FIFO master.
// Holds the default sizing and the log2 helper used to derive pointer and count widths.
package hs_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_DEPTH  = 4;

   // Ceiling log2, evaluated at elaboration time; DEPTH is a power of two so it is exact.
   function automatic int unsigned log2(input int unsigned v);
      int unsigned r;
      int unsigned p;
      r = 0;
      p = 1;
      while (p < v) begin
         p = p * 2;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/hs_fifo_ram.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
// Asynchronous reset clears every entry so the read port shows zero out of reset.
module hs_fifo_ram
   import hs_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   localparam int unsigned PTR_W = log2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [PTR_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [PTR_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/hs_fifo_master.sv
// Buffered valid/ready source: loads words on en, presents them FIFO-ordered on the output handshake.
// valid, full and level come from registered state only, so ready/en never reach them combinationally.
module hs_fifo_master
   import hs_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   localparam int unsigned PTR_W = log2(DEPTH),
   localparam int unsigned CNT_W = log2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [DATA_W-1:0] data_in,
   output logic              full,
   output logic              valid,
   input  logic              ready,
   output logic [DATA_W-1:0] data_out,
   output logic [CNT_W-1:0]  level,
   output logic              overflow
);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             accept;
   logic             pop;

   assign full   = (level == CNT_W'(DEPTH));
   assign valid  = (level != '0);
   // Full blocks loads even when a pop frees a slot in the same cycle.
   assign accept = en & ~full;
   assign pop    = valid & ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (accept && !pop) begin
            level <= level + CNT_W'(1);
         end else if (!accept && pop) begin
            level <= level - CNT_W'(1);
         end
         if (en && full) begin
            overflow <= 1'b1;
         end
      end
   end

   hs_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (accept),
      .waddr (wr_ptr),
      .wdata (data_in),
      .raddr (rd_ptr),
      .rdata (data_out)
   );

endmodule

// File: tb/tb_hs_fifo_master.sv
// Directed bench for hs_fifo_master (DATA_W=32, DEPTH=4) with a queue scoreboard.
module tb_hs_fifo_master;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;

   logic              clk;
   logic              rst_n;
   logic              en;
   logic [DATA_W-1:0] data_in;
   logic              full;
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data_out;
   logic [2:0]        level;
   logic              overflow;

   hs_fifo_master #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .data_in  (data_in),
      .full     (full),
      .valid    (valid),
      .ready    (ready),
      .data_out (data_out),
      .level    (level),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   logic [DATA_W-1:0] sb [$];
   logic              ov_m;
   logic              hold_ok;
   logic [DATA_W-1:0] hold_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Compare outputs against the model, then advance model and DUT by one clock.
   task automatic cycle();
      logic pop_m;
      logic acc_m;
      chk("valid", {31'd0, valid}, {31'd0, sb.size() != 0});
      chk("level", {29'd0, level}, 32'(sb.size()));
      chk("full", {31'd0, full}, {31'd0, sb.size() == DEPTH});
      chk("overflow", {31'd0, overflow}, {31'd0, ov_m});
      if (sb.size() != 0) chk("data_out", data_out, sb[0]);
      if (hold_ok) chk("stable", data_out, hold_data);
      pop_m = (sb.size() != 0) && ready;
      acc_m = en && (sb.size() < DEPTH);
      if (en && sb.size() == DEPTH) ov_m = 1'b1;
      if (pop_m) void'(sb.pop_front());
      if (acc_m) sb.push_back(data_in);
      hold_ok = (sb.size() != 0) && !pop_m && !acc_m ? 1'b1 : ((sb.size() != 0) && !pop_m);
      if (hold_ok) hold_data = sb[0];
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; ready = 1'b0; data_in = '0;
      ov_m = 1'b0; hold_ok = 1'b0; hold_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_level", {29'd0, level}, 32'd0);
      chk("rst_full", {31'd0, full}, 32'd0);
      chk("rst_dout", data_out, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // single word latency
      en = 1'b1; data_in = 32'hA5A5_0001;
      cycle();
      en = 1'b0;
      chk("lat_valid", {31'd0, valid}, 32'd1);
      chk("lat_dout", data_out, 32'hA5A5_0001);
      chk("lat_level", {29'd0, level}, 32'd1);
      cycle();
      ready = 1'b1; cycle(); ready = 1'b0; cycle();

      // fill past capacity with ready low
      for (int i = 1; i <= 5; i++) begin
         en = 1'b1; data_in = 32'(i);
         cycle();
      end
      en = 1'b0;
      chk("fill_full", {31'd0, full}, 32'd1);
      chk("fill_ovf", {31'd0, overflow}, 32'd1);
      cycle();
      ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("fill_order", data_out, 32'(i));
         cycle();
      end
      ready = 1'b0;
      cycle();

      // full with simultaneous load and pop
      for (int i = 0; i < 4; i++) begin
         en = 1'b1; data_in = 32'h10 + 32'(i);
         cycle();
      end
      en = 1'b1; ready = 1'b1; data_in = 32'h99;
      cycle();
      en = 1'b0; ready = 1'b0;
      chk("fp_level", {29'd0, level}, 32'd3);
      chk("fp_head", data_out, 32'h11);
      cycle();
      ready = 1'b1;
      repeat (3) cycle();
      ready = 1'b0;

      // streaming at one word per cycle
      en = 1'b1; ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         data_in = 32'h100 + 32'(i);
         cycle();
         chk("stream_level", {29'd0, level}, 32'd1);
         chk("stream_dout", data_out, 32'h100 + 32'(i));
      end
      en = 1'b0;
      cycle();
      ready = 1'b0;
      cycle();

      // random ready, data must hold until popped
      for (int i = 0; i < 3; i++) begin
         en = 1'b1; data_in = 32'hC0DE_0000 + 32'(i);
         cycle();
      end
      en = 1'b0;
      for (int i = 0; i < 20; i++) begin
         ready = 1'($urandom_range(0, 1));
         cycle();
      end
      ready = 1'b1;
      repeat (4) cycle();
      ready = 1'b0;
      cycle();

      // reset with three words buffered
      for (int i = 0; i < 3; i++) begin
         en = 1'b1; data_in = 32'hDEAD_0000 + 32'(i);
         cycle();
      end
      en = 1'b0;
      chk("pre_rst_level", {29'd0, level}, 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, valid}, 32'd0);
      chk("mid_rst_level", {29'd0, level}, 32'd0);
      chk("mid_rst_dout", data_out, 32'd0);
      chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
      sb.delete(); ov_m = 1'b0; hold_ok = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ready = 1'b1;
      repeat (3) cycle();
      chk("post_rst_dout", data_out, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
